// File: rtl/div_seq_32_bit.sv
// div_seq_32_bit
//   Multi-cycle signed 32-bit non-restoring divider for the ALU DIV path.
//   One quotient bit is produced per clock. A normal division takes 33 edges
//   from the accepting edge to valid C. A zero divisor takes 1 edge.
//
// Ports
//   clock        system clock, rising edge
//   clear        asynchronous active-low reset
//   start        one-cycle request, sampled only while idle
//   Y            dividend (two's complement), sampled on the accepting edge
//   BusMuxOut    divisor  (two's complement), sampled on the accepting edge
//   busy         high while a division is in progress
//   done         one-cycle pulse when C is valid
//   div_by_zero  set with done when the divisor was 0, cleared on next accept
//   C            {remainder, quotient}, held from done until the next result
module div_seq_32_bit (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] Y,
    input  logic [31:0] BusMuxOut,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [63:0] C
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } state_t;

    state_t      state, state_next;

    logic [32:0] a;          // signed partial remainder
    logic [31:0] q;          // quotient bits (dividend magnitude at start)
    logic [31:0] m;          // divisor magnitude
    logic [4:0]  cnt;        // iteration counter 0..31
    logic        sign_y;
    logic        sign_m;

    logic        accept;
    logic [31:0] mag_y;
    logic [31:0] mag_m;
    logic [32:0] a_shift;
    logic [32:0] a_step;
    logic [32:0] a_fix;
    logic [31:0] quo;
    logic [31:0] rem;

    assign accept = (state == IDLE) && start;
    assign busy   = (state != IDLE);

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude of -2^31.
    assign mag_y = Y[31]         ? (~Y + 32'd1)         : Y;
    assign mag_m = BusMuxOut[31] ? (~BusMuxOut + 32'd1) : BusMuxOut;

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (BusMuxOut == 32'd0) ? ZERO : RUN;
            RUN:  if (cnt == 5'd31) state_next = FIX;
            FIX:  state_next = IDLE;
            ZERO: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= state_next;
    end

    // Iteration and correction arithmetic
    always_comb begin
        a_shift = {a[31:0], q[31]};
        a_step  = a_shift;
        a_fix   = a;
        // Non-restoring step: the sign of A before the shift picks subtract
        // or add-back.
        if (!a[32]) a_step = a_shift - {1'b0, m};
        else        a_step = a_shift + {1'b0, m};
        if (a[32])  a_fix  = a + {1'b0, m};
        quo = (sign_y ^ sign_m) ? (~q + 32'd1) : q;
        rem = sign_y ? (~a_fix[31:0] + 32'd1) : a_fix[31:0];
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            a           <= 33'd0;
            q           <= 32'd0;
            m           <= 32'd0;
            cnt         <= 5'd0;
            sign_y      <= 1'b0;
            sign_m      <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            C           <= 64'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_y      <= Y[31];
                        sign_m      <= BusMuxOut[31];
                        m           <= mag_m;
                        a           <= 33'd0;
                        cnt         <= 5'd0;
                        div_by_zero <= 1'b0;
                        // With a zero divisor no iteration runs; Q carries the
                        // raw dividend into the HI half of the result instead.
                        q           <= (BusMuxOut == 32'd0) ? Y : mag_y;
                    end
                end
                RUN: begin
                    a   <= a_step;
                    q   <= {q[30:0], ~a_step[32]};
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    a    <= a_fix;
                    C    <= {rem, quo};
                    done <= 1'b1;
                end
                ZERO: begin
                    C           <= {q, 32'hFFFF_FFFF};
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
